mul_div_unit: RTL and testbench



---
 rtl/mul_div_unit.sv | 151 +++++++++++++++
 tb/tb_mul_div_unit.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage.
// One radix-2 step per cycle, fixed latency, valid/ready on both sides.
module mul_div_unit #(
   parameter int WIDTH = 32,
   parameter int OP_W  = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             flush_i,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic [OP_W-1:0]  op_i,
   input  logic [WIDTH-1:0] data1_i,
   input  logic [WIDTH-1:0] data2_i,
   output logic             valid_o,
   input  logic             ready_i,
   output logic [WIDTH-1:0] data_o,
   output logic             Zero_o,
   output logic             busy_o
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [OP_W-1:0] OP_MUL  = OP_W'(0);
   localparam logic [OP_W-1:0] OP_DIV  = OP_W'(1);
   localparam logic [OP_W-1:0] OP_DIVU = OP_W'(2);
   localparam logic [OP_W-1:0] OP_REM  = OP_W'(3);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_FIX, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [OP_W-1:0]  op_q, op_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic             neg_q, neg_d;
   logic             sgn1_q, sgn1_d;
   logic             div0_q, div0_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             zero_q, zero_d;

   logic             is_signed;
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH+1:0] trial;
   logic [WIDTH-1:0] res;

   assign ready_o = (state_q == S_IDLE);
   assign valid_o = (state_q == S_DONE);
   assign busy_o  = (state_q != S_IDLE);
   assign data_o  = data_q;
   assign Zero_o  = zero_q;

   // a_q holds the multiplier / dividend-then-quotient,
   // acc_q the product / partial remainder.
   assign is_signed = (op_i == OP_DIV) || (op_i == OP_REM);
   assign rem_sh    = {acc_q, a_q[WIDTH-1]};
   assign trial     = {1'b0, rem_sh} - {2'b00, b_q};

   always_comb begin
      res = acc_q;
      case (op_q)
         OP_MUL:  res = acc_q;
         OP_DIVU: res = div0_q ? '1 : a_q;
         OP_DIV:  res = div0_q ? '1 : (neg_q ? -a_q : a_q);
         OP_REM:  res = sgn1_q ? -acc_q : acc_q;
         default: res = acc_q;
      endcase
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      acc_d   = acc_q;
      neg_d   = neg_q;
      sgn1_d  = sgn1_q;
      div0_d  = div0_q;
      data_d  = data_q;
      zero_d  = zero_q;
      unique case (state_q)
         S_IDLE: begin
            if (valid_i) begin
               state_d = S_BUSY;
               cnt_d   = '0;
               op_d    = op_i;
               acc_d   = '0;
               a_d     = (is_signed && data1_i[WIDTH-1]) ? -data1_i : data1_i;
               b_d     = (is_signed && data2_i[WIDTH-1]) ? -data2_i : data2_i;
               neg_d   = data1_i[WIDTH-1] ^ data2_i[WIDTH-1];
               sgn1_d  = data1_i[WIDTH-1];
               div0_d  = (data2_i == '0);
            end
         end
         S_BUSY: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH-1)) state_d = S_FIX;
            if (op_q == OP_MUL) begin
               if (a_q[0]) acc_d = acc_q + b_q;
               b_d = b_q << 1;
               a_d = a_q >> 1;
            end else if (!trial[WIDTH+1]) begin
               acc_d = trial[WIDTH-1:0];
               a_d   = {a_q[WIDTH-2:0], 1'b1};
            end else begin
               acc_d = rem_sh[WIDTH-1:0];
               a_d   = {a_q[WIDTH-2:0], 1'b0};
            end
         end
         S_FIX: begin
            state_d = S_DONE;
            data_d  = res;
            zero_d  = (res == '0);
         end
         S_DONE: begin
            if (ready_i) state_d = S_IDLE;
         end
      endcase
      if (flush_i) state_d = S_IDLE;
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         neg_q   <= 1'b0;
         sgn1_q  <= 1'b0;
         div0_q  <= 1'b0;
         data_q  <= '0;
         zero_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         neg_q   <= neg_d;
         sgn1_q  <= sgn1_d;
         div0_q  <= div0_d;
         data_q  <= data_d;
         zero_q  <= zero_d;
      end
   end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit against an arithmetic reference model.
// Directed RV32M cases, random operations, backpressure, flush and reset.
module tb_mul_div_unit;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b0;
   logic        flush_i = 1'b0;
   logic        valid_i = 1'b0;
   logic        ready_o;
   logic [1:0]  op_i = 2'd0;
   logic [31:0] data1_i = '0;
   logic [31:0] data2_i = '0;
   logic        valid_o;
   logic        ready_i = 1'b0;
   logic [31:0] data_o;
   logic        Zero_o;
   logic        busy_o;

   int passed = 0;
   int total  = 0;

   localparam int LAT = 33;

   mul_div_unit #(.WIDTH(32), .OP_W(2)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
      .valid_i(valid_i), .ready_o(ready_o), .op_i(op_i),
      .data1_i(data1_i), .data2_i(data2_i),
      .valid_o(valid_o), .ready_i(ready_i),
      .data_o(data_o), .Zero_o(Zero_o), .busy_o(busy_o)
   );

   always #5 clk_i = ~clk_i;

   function automatic logic [31:0] model(input logic [1:0] op,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
      case (op)
         2'd0: return a * b;
         2'd1: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
            return 32'($signed(a) / $signed(b));
         end
         2'd2: begin
            if (b == 0) return 32'hFFFF_FFFF;
            return a / b;
         end
         default: begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
            return 32'($signed(a) % $signed(b));
         end
      endcase
   endfunction

   task automatic accept(input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b);
      @(negedge clk_i);
      op_i = op; data1_i = a; data2_i = b; valid_i = 1'b1;
      @(posedge clk_i); #1;
      valid_i = 1'b0;
      op_i = 2'($urandom); data1_i = $urandom; data2_i = $urandom;
   endtask

   task automatic wait_valid(output int lat);
      lat = 0;
      while (!valid_o && lat < 60) begin
         @(posedge clk_i); #1;
         lat++;
      end
   endtask

   task automatic run_op(input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, output logic [31:0] res,
                         output logic z, output int lat);
      accept(op, a, b);
      wait_valid(lat);
      res = data_o;
      z = Zero_o;
      @(negedge clk_i); ready_i = 1'b1;
      @(posedge clk_i); #1; ready_i = 1'b0;
   endtask

   task automatic check_op(input string name, input logic [1:0] op,
                           input logic [31:0] a, input logic [31:0] b,
                           input bit chk_lat);
      logic [31:0] res, exp;
      logic z;
      int lat;
      exp = model(op, a, b);
      run_op(op, a, b, res, z, lat);
      total++;
      if (res !== exp || z !== (exp == 0))
         $display("FAIL %s: data=%h zero=%b, want data=%h zero=%b",
                  name, res, z, exp, exp == 0);
      else passed++;
      if (chk_lat) begin
         total++;
         if (lat !== LAT)
            $display("FAIL %s latency: got %0d edges, want %0d", name, lat, LAT);
         else passed++;
      end
   endtask

   task automatic test_reset;
      #1;
      total++;
      if ({ready_o, valid_o, busy_o, Zero_o, data_o} !== {4'b1000, 32'd0})
         $display("FAIL reset: rdy=%b vld=%b busy=%b z=%b d=%h, want 1 0 0 0 0",
                  ready_o, valid_o, busy_o, Zero_o, data_o);
      else passed++;
      @(negedge clk_i); rst_i = 1'b1;
   endtask

   task automatic test_reset_mid;
      accept(2'd0, 32'd3, 32'd5);
      repeat (9) @(posedge clk_i);
      #2 rst_i = 1'b0;
      #1;
      total++;
      if ({ready_o, valid_o, busy_o} !== 3'b100)
         $display("FAIL reset_mid: rdy=%b vld=%b busy=%b, want 1 0 0",
                  ready_o, valid_o, busy_o);
      else passed++;
      @(negedge clk_i); rst_i = 1'b1;
      check_op("reset_mid_mul", 2'd0, 32'd3, 32'd5, 1'b1);
   endtask

   task automatic test_mul;
      check_op("mul_wrap", 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
      check_op("mul_zero", 2'd0, 32'h0001_0000, 32'h0001_0000, 1'b1);
      check_op("mul_small", 2'd0, 32'd1234, 32'd5678, 1'b0);
   endtask

   task automatic test_div;
      check_op("div_neg", 2'd1, 32'hFFFF_FFF9, 32'd2, 1'b1);
      check_op("rem_neg", 2'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
      check_op("divu_big", 2'd2, 32'hFFFF_FFF9, 32'd2, 1'b1);
      check_op("rem_pos_negdiv", 2'd3, 32'd7, 32'hFFFF_FFFE, 1'b0);
   endtask

   task automatic test_corners;
      check_op("div_by0", 2'd1, 32'd5, 32'd0, 1'b1);
      check_op("rem_by0", 2'd3, 32'd5, 32'd0, 1'b0);
      check_op("divu_by0", 2'd2, 32'd5, 32'd0, 1'b0);
      check_op("div_ovf", 2'd1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
      check_op("rem_ovf", 2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      check_op("div_negby0", 2'd1, 32'hFFFF_FFF0, 32'd0, 1'b0);
   endtask

   task automatic test_random;
      logic [1:0] op;
      logic [31:0] a, b;
      for (int i = 0; i < 40; i++) begin
         op = 2'($urandom_range(0, 3));
         a = $urandom;
         case ($urandom_range(0, 9))
            0: b = 32'd0;
            1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            2: b = $urandom_range(1, 20);
            3: b = -$urandom_range(1, 20);
            default: b = $urandom;
         endcase
         check_op("random", op, a, b, i < 4);
      end
   endtask

   task automatic test_backpressure;
      logic [31:0] held;
      int lat;
      accept(2'd2, 32'd100, 32'd7);
      wait_valid(lat);
      held = data_o;
      total++;
      if (held !== 32'd14)
         $display("FAIL bp_data: got %h, want %h", held, 32'd14);
      else passed++;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk_i); #1;
         total++;
         if ({valid_o, ready_o, busy_o} !== 3'b101 || data_o !== 32'd14)
            $display("FAIL bp_hold: vld=%b rdy=%b busy=%b d=%h, want 1 0 1 %h",
                     valid_o, ready_o, busy_o, data_o, 32'd14);
         else passed++;
      end
      @(negedge clk_i); ready_i = 1'b1;
      @(posedge clk_i); #1; ready_i = 1'b0;
      total++;
      if ({valid_o, ready_o, busy_o} !== 3'b010)
         $display("FAIL bp_release: vld=%b rdy=%b busy=%b, want 0 1 0",
                  valid_o, ready_o, busy_o);
      else passed++;
   endtask

   task automatic test_flush;
      bit seen;
      accept(2'd0, 32'd9, 32'd9);
      repeat (7) @(posedge clk_i);
      @(negedge clk_i); flush_i = 1'b1;
      @(posedge clk_i); #1; flush_i = 1'b0;
      total++;
      if ({ready_o, busy_o, valid_o} !== 3'b100)
         $display("FAIL flush_busy: rdy=%b busy=%b vld=%b, want 1 0 0",
                  ready_o, busy_o, valid_o);
      else passed++;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk_i); #1;
         if (valid_o) seen = 1'b1;
      end
      total++;
      if (seen !== 1'b0)
         $display("FAIL flush_no_valid: valid seen=%b, want 0", seen);
      else passed++;
      @(negedge clk_i);
      flush_i = 1'b1; valid_i = 1'b1; op_i = 2'd0;
      data1_i = 32'd2; data2_i = 32'd2;
      @(posedge clk_i); #1;
      flush_i = 1'b0; valid_i = 1'b0;
      total++;
      if ({ready_o, busy_o} !== 2'b10)
         $display("FAIL flush_idle: rdy=%b busy=%b, want 1 0", ready_o, busy_o);
      else passed++;
      check_op("after_flush", 2'd1, 32'd100, 32'hFFFF_FFFD, 1'b1);
   endtask

   initial begin
      test_reset;
      test_reset_mid;
      test_mul;
      test_div;
      test_corners;
      test_random;
      test_backpressure;
      test_flush;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
